// File: rtl/core_pkg.sv
// core_pkg: shared core encodings for PC state, instruction size and comparator ops
package core_pkg;

    typedef enum logic [1:0] {
        PC_STATE_BOOT  = 2'd0,
        PC_STATE_RUN   = 2'd1,
        PC_STATE_FLUSH = 2'd2
    } pc_state_e;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        CMP_BEQ  = 3'd0,
        CMP_BNE  = 3'd1,
        CMP_BLT  = 3'd2,
        CMP_BGE  = 3'd3,
        CMP_BLTU = 3'd4,
        CMP_BGEU = 3'd5
    } cmp_op_e;

endpackage

// File: rtl/pc_unit.sv
// pc_unit: fetch PC generator with taken-branch/jump redirect and fixed-length flush
module pc_unit
    import core_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            imem_ready,
    input  logic            br_valid,
    input  logic            b,
    input  logic            jmp_valid,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            flush,
    output logic            misalign
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    pc_state_e       state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [XLEN-1:0] pc_nxt, t;
    logic            redirect, bad_target, go, hold;

    // JALR clears bit 0; bit 1 left set means the target is not word aligned
    assign t          = target & ~XLEN'(1);
    assign redirect   = (state == PC_STATE_RUN) & ((br_valid & b) | jmp_valid);
    assign bad_target = redirect & t[1];
    assign go         = redirect & ~t[1];
    assign hold       = stall | ~imem_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PC_STATE_BOOT;
        else        state <= state_nxt;
    end

    // Next state: BOOT lasts one cycle, a good redirect enters FLUSH, counter expiry returns to RUN
    always_comb begin
        state_nxt = (state == PC_STATE_BOOT)                   ? PC_STATE_RUN   :
                    go                                         ? PC_STATE_FLUSH :
                    (state == PC_STATE_FLUSH && cnt == '0)     ? PC_STATE_RUN   :
                                                                 state;
    end

    // Next PC, flush counter and misalign pulse; redirect wins over stall and imem back-pressure
    always_comb begin
        pc_nxt  = (state == PC_STATE_BOOT || bad_target) ? pc :
                  go                                     ? t  :
                  hold                                   ? pc :
                                                           pc + XLEN'(INSTR_BYTES);
        cnt_nxt = go                                      ? CW'(FLUSH_CYCLES - 1) :
                  (state == PC_STATE_FLUSH && cnt != '0)  ? cnt - CW'(1)          :
                                                            cnt;
    end

    // Registered datapath outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            cnt      <= '0;
            misalign <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            cnt      <= cnt_nxt;
            misalign <= bad_target;
        end
    end

    assign pc_valid = state != PC_STATE_BOOT;
    assign flush    = state == PC_STATE_FLUSH;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: randomized and directed checks of pc_unit against a behavioural fetch model
module tb_pc_unit;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          FC       = 2;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        stall = 1'b0, imem_ready = 1'b1, br_valid = 1'b0, b = 1'b0, jmp_valid = 1'b0;
    logic [31:0] target = '0;
    logic [31:0] pc;
    logic        pc_valid, flush, misalign;

    pc_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .imem_ready(imem_ready),
        .br_valid(br_valid), .b(b), .jmp_valid(jmp_valid), .target(target),
        .pc(pc), .pc_valid(pc_valid), .flush(flush), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    logic [31:0] m_pc;
    bit          m_booted;
    int          m_flush_left;
    bit          m_mis;

    logic [34:0] act;
    assign act = {pc, pc_valid, flush, misalign};

    function automatic logic [34:0] exp_vec();
        return {m_pc, m_booted, m_flush_left > 0, m_mis};
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_booted = 0; m_flush_left = 0; m_mis = 0;
    endtask

    task automatic step();
        logic [31:0] tt;
        bit take, hold;
        @(posedge clk);
        if (rst_n) begin
            tt   = target & 32'hFFFF_FFFE;
            take = jmp_valid || (br_valid && b);
            hold = stall || !imem_ready;
            m_mis = 0;
            if (!m_booted) m_booted = 1;
            else if (m_flush_left > 0) begin
                m_flush_left--;
                if (!hold) m_pc = m_pc + 32'd4;
            end
            else if (take && tt[1]) m_mis = 1;
            else if (take) begin m_pc = tt; m_flush_left = FC; end
            else if (!hold) m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; imem_ready = 1; br_valid = 0; b = 0; jmp_valid = 0; target = '0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        step();
    endtask

    task automatic advance(input int n);
        repeat (n) step();
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
        idle_inputs();
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (act !== {RESET_PC, 3'b000}) begin errors++; $display("FAIL reset_assert: got %h want %h", act, {RESET_PC, 3'b000}); end
        repeat (5) @(posedge clk);
        @(negedge clk) rst_n = 1;
        checks++;
        if (pc_valid !== 1'b0 || pc !== RESET_PC) begin errors++; $display("FAIL boot: got pc=%h valid=%b want pc=%h valid=0", pc, pc_valid, RESET_PC); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc !== exp_pc[i] || pc_valid !== 1'b1 || act !== exp_vec()) begin
                errors++; $display("FAIL reset_seq%0d: got %h want pc=%h model %h", i, act, exp_pc[i], exp_vec());
            end
        end
    endtask

    task automatic test_branch();
        int fl;
        reset_dut();
        advance(4);
        checks++;
        if (pc !== 32'h10) begin errors++; $display("FAIL br_setup: got pc=%h want 00000010", pc); end
        br_valid = 1; b = 1; target = 32'h40;
        step();
        idle_inputs();
        checks++;
        if (pc !== 32'h40 || flush !== 1'b1 || act !== exp_vec()) begin errors++; $display("FAIL br_taken: got %h want %h", act, exp_vec()); end
        fl = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            fl += flush;
            checks++;
            if (act !== exp_vec()) begin errors++; $display("FAIL br_after%0d: got %h want %h", i, act, exp_vec()); end
        end
        checks++;
        if (fl !== FC) begin errors++; $display("FAIL br_flush_len: got %0d want %0d", fl, FC); end
        reset_dut();
        advance(4);
        br_valid = 1; b = 0; target = 32'h40;
        step();
        idle_inputs();
        checks++;
        if (pc !== 32'h14 || flush !== 1'b0) begin errors++; $display("FAIL br_not_taken: got pc=%h flush=%b want 00000014 0", pc, flush); end
    endtask

    task automatic test_branch_in_flush();
        reset_dut();
        advance(4);
        br_valid = 1; b = 1; target = 32'h40;
        step();
        target = 32'h80;
        step();
        idle_inputs();
        checks++;
        if (pc !== 32'h44 || act !== exp_vec()) begin errors++; $display("FAIL flush_ignore: got %h want pc=00000044 model %h", act, exp_vec()); end
        advance(2);
        checks++;
        if (act !== exp_vec()) begin errors++; $display("FAIL flush_ignore_tail: got %h want %h", act, exp_vec()); end
    endtask

    task automatic test_jump();
        reset_dut();
        jmp_valid = 1; target = 32'h101;
        step();
        idle_inputs();
        checks++;
        if (pc !== 32'h100 || flush !== 1'b1) begin errors++; $display("FAIL jmp_bit0: got pc=%h flush=%b want 00000100 1", pc, flush); end
        advance(3);
        jmp_valid = 1; br_valid = 1; b = 0; target = 32'h102;
        step();
        idle_inputs();
        checks++;
        if (misalign !== 1'b1 || flush !== 1'b0 || act !== exp_vec()) begin errors++; $display("FAIL jmp_misalign: got %h want %h", act, exp_vec()); end
        step();
        checks++;
        if (misalign !== 1'b0 || act !== exp_vec()) begin errors++; $display("FAIL misalign_pulse: got %h want %h", act, exp_vec()); end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        reset_dut();
        advance(8);
        held = pc;
        stall = 1;
        advance(3);
        checks++;
        if (pc !== 32'h20 || pc !== held) begin errors++; $display("FAIL stall_hold: got pc=%h want 00000020", pc); end
        jmp_valid = 1; target = 32'h200;
        step();
        jmp_valid = 0;
        checks++;
        if (pc !== 32'h200 || act !== exp_vec()) begin errors++; $display("FAIL stall_redirect: got %h want %h", act, exp_vec()); end
        imem_ready = 0;
        advance(3);
        checks++;
        if (pc !== 32'h200 || act !== exp_vec()) begin errors++; $display("FAIL ready_hold: got %h want %h", act, exp_vec()); end
        idle_inputs();
    endtask

    task automatic test_wrap_and_reset();
        reset_dut();
        jmp_valid = 1; target = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        step();
        checks++;
        if (pc !== 32'h0 || act !== exp_vec()) begin errors++; $display("FAIL wrap: got %h want pc=00000000 model %h", act, exp_vec()); end
        jmp_valid = 1; target = 32'h40;
        advance(2);
        step();
        idle_inputs();
        checks++;
        if (flush !== 1'b1) begin errors++; $display("FAIL pre_reset_flush: got %b want 1", flush); end
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (flush !== 1'b0 || pc !== RESET_PC || pc_valid !== 1'b0) begin errors++; $display("FAIL reset_in_flush: got %h want %h", act, {RESET_PC, 3'b000}); end
        @(negedge clk) rst_n = 1;
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) reset_dut();
            stall      = ($urandom_range(0, 4) == 0);
            imem_ready = ($urandom_range(0, 4) != 0);
            br_valid   = ($urandom_range(0, 3) == 0);
            b          = $urandom_range(0, 1) == 1;
            jmp_valid  = ($urandom_range(0, 7) == 0);
            target     = $urandom;
            step();
            checks++;
            if (act !== exp_vec()) begin errors++; $display("FAIL rand%0d: got %h want %h", i, act, exp_vec()); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_branch();
        test_branch_in_flush();
        test_jump();
        test_stall();
        test_wrap_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
